// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte type, FSM state encoding, the FIPS-197 forward and
// inverse S-box tables, and a single lookup helper used by every S-box lane.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Both tables are fully populated, so any 8-bit input yields a defined byte.
    function automatic byte_t sbox_lookup(input byte_t b, input logic inv);
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/sbox_fi.sv
// sbox_fi: one combinational AES S-box lane; inverse selects InvSubBytes.
module sbox_fi
    import aes_pkg::*;
(
    input  byte_t byte_in,
    input  logic  inverse,
    output byte_t byte_out
);

    // Pure table lookup; the table choice follows the transaction's mode bit.
    assign byte_out = sbox_lookup(byte_in, inverse);

endmodule

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: iterative AES SubBytes / InvSubBytes over an N x N byte state.
// LANES S-box lanes sweep the captured state in row-major order, LANES bytes per
// beat, writing results back in place until all BEATS beats are done.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int N     = 4,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     inverse,
    input  logic [N-1:0][N-1:0][7:0] bytes_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0][N-1:0][7:0] bytes_out,
    output logic                     busy
);

    localparam int BYTES = N * N;
    localparam int BEATS = BYTES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    // A lane count that does not tile the state would leave bytes unprocessed.
    if (LANES < 1 || (BYTES % LANES) != 0) begin : g_lanes_check
        $error("sub_bytes_seq: LANES (%0d) must divide N*N (%0d)", LANES, BYTES);
    end

    state_t                 r_fsm;
    logic [CW-1:0]          r_beat;
    logic                   r_inverse;
    logic                   r_outValid;
    logic [BYTES-1:0][7:0]  r_state;

    logic [IW-1:0]          w_laneIdx [LANES];
    byte_t                  w_laneIn  [LANES];
    byte_t                  w_laneOut [LANES];
    logic                   w_lastBeat;

    // The beat counter never advances when BEATS == 1, so lane indices stay 0..LANES-1.
    assign w_lastBeat = (int'(r_beat) == (BEATS - 1));

    // Each lane reads byte (beat*LANES + lane) of the row-major state.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_laneIdx[l] = IW'(int'(r_beat) * LANES + l);
        assign w_laneIn[l]  = r_state[w_laneIdx[l]];

        sbox_fi u_sbox (
            .byte_in  (w_laneIn[l]),
            .inverse  (r_inverse),
            .byte_out (w_laneOut[l])
        );
    end

    // Control FSM plus the in-place state register; reset discards any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= ST_IDLE;
            r_beat     <= '0;
            r_inverse  <= 1'b0;
            r_outValid <= 1'b0;
            r_state    <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_state   <= bytes_in;
                        r_inverse <= inverse;
                        r_beat    <= '0;
                        r_fsm     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_state[w_laneIdx[l]] <= w_laneOut[l];
                    end
                    if (w_lastBeat) begin
                        r_beat     <= '0;
                        r_outValid <= 1'b1;
                        r_fsm      <= ST_DONE;
                    end else begin
                        r_beat <= r_beat + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_fsm      <= ST_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_fsm      <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_fsm == ST_IDLE) && !rst;
    assign busy      = (r_fsm != ST_IDLE);
    assign out_valid = r_outValid;
    assign bytes_out = r_state;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: directed bench for sub_bytes_seq (N=4, LANES=4) plus a set of
// LANES=1/2/8/16 instances swept over every byte value in both modes.
module tb_sub_bytes_seq;

    typedef logic [3:0][3:0][7:0] stateT;

    localparam int NSWEEP = 4;
    localparam int SWEEP_LAT [NSWEEP] = '{16, 8, 2, 1};

    logic  clk = 1'b0;
    logic  rst;
    logic  inValid;
    logic  inReady;
    logic  inverse;
    logic  outValid;
    logic  outReady;
    logic  busy;
    stateT bytesIn;
    stateT bytesOut;

    logic  swInValid;
    logic  swInverse;
    logic  swOutReady;
    stateT swBytesIn;
    logic  swInReady  [NSWEEP];
    logic  swOutValid [NSWEEP];
    logic  swBusy     [NSWEEP];
    stateT swBytesOut [NSWEEP];

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] fwdRef [256];
    logic [7:0] invRef [256];

    logic [7:0] fipsIn [16] = '{8'h19, 8'ha0, 8'h9a, 8'he9, 8'h3d, 8'hf4, 8'hc6, 8'hf8,
                                8'he3, 8'he2, 8'h8d, 8'h48, 8'hbe, 8'h2b, 8'h2a, 8'h08};
    logic [7:0] fipsOut [16] = '{8'hd4, 8'he0, 8'hb8, 8'h1e, 8'h27, 8'hbf, 8'hb4, 8'h41,
                                 8'h11, 8'h98, 8'h5d, 8'h52, 8'hae, 8'hf1, 8'he5, 8'h30};

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    sub_bytes_seq #(.N(4), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .inverse   (inverse),
        .bytes_in  (bytesIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .bytes_out (bytesOut),
        .busy      (busy)
    );

    for (genvar g = 0; g < NSWEEP; g++) begin : g_sweep
        localparam int LANES_G = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        sub_bytes_seq #(.N(4), .LANES(LANES_G)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (swInValid),
            .in_ready  (swInReady[g]),
            .inverse   (swInverse),
            .bytes_in  (swBytesIn),
            .out_valid (swOutValid[g]),
            .out_ready (swOutReady),
            .bytes_out (swBytesOut[g]),
            .busy      (swBusy[g])
        );
    end

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box from first principles: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] refSbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gfMul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic stateT packBytes(input logic [7:0] b [16]);
        stateT s;
        for (int i = 0; i < 16; i++) s[i / 4][i % 4] = b[i];
        return s;
    endfunction

    function automatic stateT fillState(input logic [7:0] v);
        stateT s;
        for (int i = 0; i < 16; i++) s[i / 4][i % 4] = v;
        return s;
    endfunction

    task automatic buildRef();
        for (int x = 0; x < 256; x++) begin
            fwdRef[x] = refSbox(8'(x));
            invRef[fwdRef[x]] = 8'(x);
        end
    endtask

    task automatic applyStimulus(input stateT st, input logic inv);
        int n;
        n = 0;
        bytesIn = st;
        inverse = inv;
        inValid = 1'b1;
        while (inReady !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkCount++;
        if (inReady !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL accept_wait: in_ready=%b required 1", inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic waitOutput(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (outValid !== 1'b1 && cycles < 100);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        inValid    = 1'b0;
        inverse    = 1'b0;
        bytesIn    = '0;
        outReady   = 1'b0;
        swInValid  = 1'b0;
        swInverse  = 1'b0;
        swBytesIn  = '0;
        swOutReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (inReady !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_in_ready: got %b required 0", inReady); end
        checkCount++;
        if (outValid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_out_valid: got %b required 0", outValid); end
        checkCount++;
        if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checkCount++;
        if (bytesOut !== '0) begin errorCount++; $display("[TB] FAIL reset_bytes_out: got %h required 0", bytesOut); end
        rst = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (inReady !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_release_ready: got %b required 1", inReady); end
    endtask

    task automatic test_zero_forward();
        int cycles;
        int badCtl;
        outReady = 1'b1;
        applyStimulus(fillState(8'h00), 1'b0);
        cycles = 0;
        badCtl = 0;
        do begin
            if (inReady !== 1'b0 || busy !== 1'b1) badCtl++;
            @(posedge clk); #1;
            cycles++;
        end while (outValid !== 1'b1 && cycles < 100);
        checkCount++;
        if (cycles !== 4) begin errorCount++; $display("[TB] FAIL zero_latency: got %0d required 4", cycles); end
        checkCount++;
        if (bytesOut !== fillState(8'h63)) begin errorCount++; $display("[TB] FAIL zero_data: got %h required all 63", bytesOut); end
        checkCount++;
        if (badCtl !== 0) begin errorCount++; $display("[TB] FAIL zero_run_ctl: bad samples %0d required 0", badCtl); end
        checkCount++;
        if (inReady !== 1'b0 || busy !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL zero_done_ctl: in_ready=%b busy=%b required 0/1", inReady, busy);
        end
        @(posedge clk); #1;
        checkCount++;
        if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL zero_handshake: out_valid=%b in_ready=%b busy=%b required 0/1/0", outValid, inReady, busy);
        end
    endtask

    task automatic test_fips_round();
        int    cycles;
        stateT got;
        stateT expOut;
        stateT expIn;
        expOut   = packBytes(fipsOut);
        expIn    = packBytes(fipsIn);
        outReady = 1'b1;
        applyStimulus(expIn, 1'b0);
        waitOutput(cycles);
        got = bytesOut;
        checkCount++;
        if (got[0] !== expOut[0]) begin errorCount++; $display("[TB] FAIL fips_fwd_row0: got %h required %h", got[0], expOut[0]); end
        checkCount++;
        if (got !== expOut) begin errorCount++; $display("[TB] FAIL fips_fwd_full: got %h required %h", got, expOut); end
        @(posedge clk); #1;
        applyStimulus(got, 1'b1);
        waitOutput(cycles);
        checkCount++;
        if (bytesOut[0] !== expIn[0]) begin errorCount++; $display("[TB] FAIL fips_inv_row0: got %h required %h", bytesOut[0], expIn[0]); end
        checkCount++;
        if (bytesOut !== expIn) begin errorCount++; $display("[TB] FAIL fips_roundtrip: got %h required %h", bytesOut, expIn); end
        checkCount++;
        if (cycles !== 4) begin errorCount++; $display("[TB] FAIL fips_inv_latency: got %0d required 4", cycles); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int    cycles;
        stateT expOut;
        expOut   = packBytes(fipsOut);
        outReady = 1'b0;
        applyStimulus(packBytes(fipsIn), 1'b0);
        waitOutput(cycles);
        for (int i = 0; i < 10; i++) begin
            inValid = i[0];
            inverse = ~i[0];
            bytesIn = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            checkCount++;
            if (outValid !== 1'b1 || bytesOut !== expOut || inReady !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b data=%h required 1/0/%h",
                         i, outValid, inReady, bytesOut, expOut);
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (outValid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_release_valid: got %b required 0", outValid); end
        checkCount++;
        if (inReady !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_release_ready: got %b required 1", inReady); end
    endtask

    task automatic test_mode_sampling();
        int cycles;
        outReady = 1'b1;
        applyStimulus(fillState(8'h53), 1'b0);
        inverse = 1'b1;
        bytesIn = fillState(8'hff);
        waitOutput(cycles);
        checkCount++;
        if (bytesOut !== fillState(8'hed)) begin errorCount++; $display("[TB] FAIL mode_fwd_53: got %h required all ed", bytesOut); end
        @(posedge clk); #1;
        applyStimulus(fillState(8'h63), 1'b1);
        inverse = 1'b0;
        waitOutput(cycles);
        checkCount++;
        if (bytesOut !== fillState(8'h00)) begin errorCount++; $display("[TB] FAIL mode_inv_63: got %h required all 00", bytesOut); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int    cycles;
        stateT expOut;
        expOut   = packBytes(fipsOut);
        outReady = 1'b1;
        applyStimulus(fillState(8'h11), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (busy !== 1'b0 || outValid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL midrst_ctl: busy=%b out_valid=%b required 0/0", busy, outValid);
        end
        checkCount++;
        if (bytesOut !== '0) begin errorCount++; $display("[TB] FAIL midrst_bytes: got %h required 0", bytesOut); end
        checkCount++;
        if (inReady !== 1'b0) begin errorCount++; $display("[TB] FAIL midrst_in_ready: got %b required 0", inReady); end
        rst = 1'b0;
        applyStimulus(packBytes(fipsIn), 1'b0);
        waitOutput(cycles);
        checkCount++;
        if (cycles !== 4 || bytesOut !== expOut) begin
            errorCount++;
            $display("[TB] FAIL midrst_recover: latency %0d data %h required 4 / %h", cycles, bytesOut, expOut);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lane_sweep();
        stateT      st;
        stateT      expSt;
        logic [7:0] v;
        int         n;
        int         c;
        bit         seen [NSWEEP];
        swOutReady = 1'b1;
        for (int mode = 0; mode < 2; mode++) begin
            for (int t = 0; t < 16; t++) begin
                for (int i = 0; i < 16; i++) begin
                    v = 8'(t * 16 + i);
                    st[i / 4][i % 4]    = v;
                    expSt[i / 4][i % 4] = (mode != 0) ? invRef[v] : fwdRef[v];
                end
                n = 0;
                while (!(swInReady[0] && swInReady[1] && swInReady[2] && swInReady[3]) && n < 40) begin
                    @(posedge clk); #1;
                    n++;
                end
                checkCount++;
                if (!(swInReady[0] && swInReady[1] && swInReady[2] && swInReady[3])) begin
                    errorCount++;
                    $display("[TB] FAIL sweep_ready mode %0d state %0d: not all in_ready, required all 1", mode, t);
                end
                swBytesIn = st;
                swInverse = mode[0];
                swInValid = 1'b1;
                @(posedge clk); #1;
                swInValid = 1'b0;
                for (int k = 0; k < NSWEEP; k++) seen[k] = 1'b0;
                c = 0;
                while (!(seen[0] && seen[1] && seen[2] && seen[3]) && c < 40) begin
                    @(posedge clk); #1;
                    c++;
                    for (int k = 0; k < NSWEEP; k++) begin
                        if (!seen[k] && swOutValid[k] === 1'b1) begin
                            seen[k] = 1'b1;
                            checkCount++;
                            if (c !== SWEEP_LAT[k]) begin
                                errorCount++;
                                $display("[TB] FAIL sweep_latency inst %0d mode %0d state %0d: got %0d required %0d",
                                         k, mode, t, c, SWEEP_LAT[k]);
                            end
                            checkCount++;
                            if (swBytesOut[k] !== expSt || swBusy[k] !== 1'b1) begin
                                errorCount++;
                                $display("[TB] FAIL sweep_data inst %0d mode %0d state %0d: got %h busy %b required %h busy 1",
                                         k, mode, t, swBytesOut[k], swBusy[k], expSt);
                            end
                        end
                    end
                end
                for (int k = 0; k < NSWEEP; k++) begin
                    checkCount++;
                    if (!seen[k]) begin
                        errorCount++;
                        $display("[TB] FAIL sweep_timeout inst %0d mode %0d state %0d: out_valid never rose within 40 cycles", k, mode, t);
                    end
                end
            end
        end
    endtask

    // Scenario sequence; the summary line is the last thing printed.
    initial begin
        buildRef();
        test_reset();
        test_zero_forward();
        test_fips_round();
        test_backpressure();
        test_mode_sampling();
        test_reset_mid_run();
        test_lane_sweep();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Hard stop in case a scenario wedges despite its own bounds.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time 1000000, required to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
